// File: rtl/clock_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl_if
// Configuration channel of clock_div_ctrl. It carries a new half-period
// request to the divider and reports when that request is pending and when
// it has taken effect.
//
// Handshake: the master raises cfg_req for one clock_in cycle with cfg_half
// valid in that same cycle. The request is accepted only if cfg_busy is low
// in that cycle, and cfg_busy is high from the next cycle onward. A request
// made while cfg_busy is high is dropped. cfg_busy stays high until the
// divider applies the value. In the cycle the new half-period takes effect,
// cfg_ack is high for exactly one cycle and cfg_busy is low again.
//
// Signals:
//   cfg_req  : master -> slave, single-cycle change request
//   cfg_half : master -> slave, requested half-period (0 is treated as 1)
//   cfg_busy : slave -> master, a captured request is pending
//   cfg_ack  : slave -> master, one-cycle pulse when the new value takes effect
// ---------------------------------------------------------------------------
interface clock_div_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cfg_req;
    logic [WIDTH-1:0] cfg_half;
    logic             cfg_busy;
    logic             cfg_ack;

    modport master (
        output cfg_req,
        output cfg_half,
        input  cfg_busy,
        input  cfg_ack
    );

    modport slave (
        input  cfg_req,
        input  cfg_half,
        output cfg_busy,
        output cfg_ack
    );
endinterface

// File: rtl/clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl
// Programmable clock divider with a 50% duty cycle. clock_out has a period of
// 2*H clock_in cycles, where H is the active half-period. A new H can be
// requested at any time. It is applied at once while idle, and otherwise
// only at the end of a high phase, so no phase is ever stretched or cut by
// a change of H. When enable is withdrawn, a low phase is cut short at once
// and a high phase is allowed to finish first, so no runt pulse is produced.
//
// Ports:
//   clock_in  : sole clock, rising edge
//   reset     : synchronous, active-high
//   enable    : level-sensitive run request
//   cfg       : configuration channel (cfg_req/cfg_half/cfg_busy/cfg_ack)
//   clock_out : divided clock (registered)
//   tick      : one-cycle pulse in the first cycle of each high phase
//   running   : FSM is in RUN or STOP
//   state_o   : FSM state for debug (00 IDLE, 01 RUN, 10 STOP)
// ---------------------------------------------------------------------------
module clock_div_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_HALF = 2
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    enable,
    clock_div_ctrl_if.slave         cfg,
    output logic                    clock_out,
    output logic                    tick,
    output logic                    running,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] half_q;     // active half-period H
    logic [WIDTH-1:0] pend_q;     // captured, not yet applied half-period
    logic             busy_q;
    logic             ack_q;
    logic             clk_out_q;
    logic             tick_q;

    logic [WIDTH-1:0] cfg_half_d;
    logic [WIDTH-1:0] cnt_inc_d;
    logic             phase_end;
    logic             boundary;
    logic             apply_cfg;

    always_comb begin
        cfg_half_d = (cfg.cfg_half == '0) ? WIDTH'(1) : cfg.cfg_half;
        cnt_inc_d  = cnt_q + WIDTH'(1);
        phase_end  = (cnt_q == half_q - WIDTH'(1));
        // End of a high phase: the only point where H may change while the
        // divider is active.
        boundary   = (state_q != IDLE) && phase_end && clk_out_q;
        apply_cfg  = busy_q && ((state_q == IDLE) || boundary);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            half_q    <= WIDTH'(DEFAULT_HALF);
            pend_q    <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            ack_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    if (enable) begin
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (!enable && !clk_out_q) begin
                        // Low phase is simply abandoned; clock_out is already 0.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        if (phase_end) begin
                            cnt_q     <= '0;
                            clk_out_q <= ~clk_out_q;
                            tick_q    <= ~clk_out_q;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                        // High phase must finish; if it finishes in this very
                        // cycle there is nothing left to wait for.
                        if (!enable) begin
                            state_q <= boundary ? IDLE : STOP;
                        end
                    end
                end

                STOP: begin
                    // clock_out is high throughout STOP; enable is ignored.
                    if (phase_end) begin
                        cnt_q     <= '0;
                        clk_out_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                end
            endcase

            // apply_cfg needs busy_q=1 and capture needs busy_q=0, so a
            // request arriving in the apply cycle is never lost silently:
            // it is dropped exactly as any request made while busy.
            if (apply_cfg) begin
                half_q <= pend_q;
                ack_q  <= 1'b1;
                busy_q <= 1'b0;
            end else if (cfg.cfg_req && !busy_q) begin
                pend_q <= cfg_half_d;
                busy_q <= 1'b1;
            end
        end
    end

    assign clock_out    = clk_out_q;
    assign tick         = tick_q;
    assign running      = (state_q != IDLE);
    assign state_o      = state_q;
    assign cfg.cfg_busy = busy_q;
    assign cfg.cfg_ack  = ack_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_div_ctrl
// Directed scenarios for clock_div_ctrl. Each scenario pushes the expected
// output vector {state, running, clock_out, tick, cfg_busy, cfg_ack} for every
// clock edge as it drives that edge's inputs, then pops and compares it
// 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_clock_div_ctrl;

    localparam int WIDTH = 8;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STOP = 2'b10;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    clock_div_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

    logic       clock_out;
    logic       tick;
    logic       running;
    logic [1:0] state_o;

    clock_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_HALF(2)) dut (
        .clock_in  (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg       (cfg_if.slave),
        .clock_out (clock_out),
        .tick      (tick),
        .running   (running),
        .state_o   (state_o)
    );

    // scoreboard
    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] obs;
    assign obs = {state_o, running, clock_out, tick, cfg_if.cfg_busy, cfg_if.cfg_ack};

    function automatic logic [6:0] ev(input logic [1:0] st, input logic ck,
                                      input logic tk, input logic bz, input logic ak);
        return {st, (st != S_IDLE), ck, tk, bz, ak};
    endfunction

    // driver tasks
    task automatic drive(input logic en, input logic req, input logic [WIDTH-1:0] half);
        enable          = en;
        cfg_if.cfg_req  = req;
        cfg_if.cfg_half = half;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Reset wins over enable and cfg_req; first released cycles stay IDLE.
    task automatic test_reset();
        logic [6:0] exp;
        for (int e = 1; e <= 5; e++) begin
            if (e <= 3) begin
                reset = 1'b1;
                drive(1'b1, 1'b1, 8'd9);
            end else begin
                reset = 1'b0;
                drive(1'b0, 1'b0, '0);
            end
            exp_q.push_back(ev(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset e%0d: got %b required %b", e, obs, exp);
            end
        end
    endtask

    // Default H=2: 2 low / 2 high, first rise two cycles after RUN entry.
    task automatic test_default_run();
        logic [6:0] exp;
        logic ck, tk;
        apply_reset();
        for (int e = 1; e <= 14; e++) begin
            drive(1'b1, 1'b0, '0);
            ck = (((e - 1) / 2) % 2) == 1;
            tk = ck && (((e - 1) % 2) == 0);
            exp_q.push_back(ev(S_RUN, ck, tk, 1'b0, 1'b0));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL default_run e%0d: got %b required %b", e, obs, exp);
            end
        end
    endtask

    // Request H=5 during a high phase; applied at the falling edge.
    task automatic test_retune();
        logic [6:0] exp;
        logic ck;
        apply_reset();
        for (int e = 1; e <= 20; e++) begin
            drive(1'b1, (e == 4), 8'd5);
            ck = (e >= 3 && e <= 4) || (e >= 10 && e <= 14) || (e == 20);
            exp_q.push_back(ev(S_RUN, ck, (e == 3 || e == 10 || e == 20), (e == 4), (e == 5)));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL retune e%0d: got %b required %b", e, obs, exp);
            end
        end
    endtask

    // cfg_half=0 becomes H=1: clock_out toggles every cycle.
    task automatic test_half_zero();
        logic [6:0] exp;
        logic ck;
        apply_reset();
        for (int e = 1; e <= 10; e++) begin
            drive((e >= 3), (e == 1), 8'd0);
            ck = (e >= 4) && ((e % 2) == 0);
            exp_q.push_back(ev((e >= 3) ? S_RUN : S_IDLE, ck, ck, (e == 1), (e == 2)));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL half_zero e%0d: got %b required %b", e, obs, exp);
            end
        end
    endtask

    // Apply H=3 in the same cycle enable rises, then drop enable in the
    // first high cycle (STOP, phase completes), re-enable while in STOP
    // (ignored until IDLE), then drop enable in a low phase.
    task automatic test_apply_stop();
        logic [6:0] exp;
        logic en, ck;
        logic [1:0] st;
        apply_reset();
        for (int e = 1; e <= 18; e++) begin
            en = (e >= 2 && e <= 11) || (e >= 13 && e <= 16);
            drive(en, (e == 1), 8'd3);
            if (e == 1 || e == 14 || e >= 17)  st = S_IDLE;
            else if (e == 12 || e == 13)       st = S_STOP;
            else                               st = S_RUN;
            ck = (e >= 5 && e <= 7) || (e >= 11 && e <= 13);
            exp_q.push_back(ev(st, ck, (e == 5 || e == 11), (e == 1), (e == 2)));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL apply_stop e%0d: got %b required %b", e, obs, exp);
            end
        end
    endtask

    // Request in the boundary cycle is held for the next boundary; a second
    // request while busy is ignored (one ack, first value H=4 used).
    task automatic test_back_to_back();
        logic [6:0] exp;
        logic ck;
        apply_reset();
        for (int e = 1; e <= 18; e++) begin
            drive(1'b1, (e == 5 || e == 6), (e == 6) ? 8'd7 : 8'd4);
            ck = (e >= 3 && e <= 4) || (e >= 7 && e <= 8) || (e >= 13 && e <= 16);
            exp_q.push_back(ev(S_RUN, ck, (e == 3 || e == 7 || e == 13),
                               (e >= 5 && e <= 8), (e == 9)));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back e%0d: got %b required %b", e, obs, exp);
            end
        end
    endtask

    // Reset while high with a pending request: everything cleared, H back
    // to 2, pending discarded (no busy, no ack afterwards).
    task automatic test_reset_mid();
        logic [6:0] exp;
        logic [1:0] st;
        logic ck;
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            reset = (e == 5);
            if (e <= 5)      drive(1'b1, (e >= 4), 8'd6);
            else if (e <= 7) drive(1'b0, 1'b0, 8'd6);
            else             drive(1'b1, 1'b0, 8'd6);
            st = (e >= 5 && e <= 7) ? S_IDLE : S_RUN;
            ck = (e >= 3 && e <= 4) || (e >= 10 && e <= 11);
            exp_q.push_back(ev(st, ck, (e == 3 || e == 10), (e == 4), 1'b0));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid e%0d: got %b required %b", e, obs, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0);
        test_reset();
        test_default_run();
        test_retune();
        test_half_zero();
        test_apply_stop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
